serial_rx: RTL and testbench

- Memory-mapped asynchronous serial receiver on the core's operand bus.
- Receive-direction counterpart of the existing serial output device: deserialises 8N1 frames from an external `rxd` line into a small FIFO.
- The core drains the FIFO by reading a data register; reading when empty returns -1 (EOF).
- Shares `rw`, `addr` and the bidirectional `data` bus with memory and the other peripherals.

---
 rtl/serial_rx_pkg.sv | 28 ++
 rtl/serial_rx_fifo.sv | 47 ++++
 rtl/serial_rx.sv | 127 ++++++++++++
 tb/tb_serial_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receiver: register offsets, status bit
// positions, the EOF read value and the receive FSM encoding.
package serial_rx_pkg;

  localparam logic [31:0] SERIAL_RX_DATA = 32'd0;
  localparam logic [31:0] SERIAL_RX_STAT = 32'd1;

  localparam int ST_NONEMPTY  = 0;
  localparam int ST_FRAME_ERR = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_COUNT_LSB = 4;

  localparam logic [31:0] SERIAL_RX_EOF = 32'hFFFF_FFFF;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  function automatic logic [31:0] rx_status(input logic [3:0] count,
                                            input logic overrun,
                                            input logic frame_err,
                                            input logic nonempty);
    return {24'h0, count, 1'b0, overrun, frame_err, nonempty};
  endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Byte FIFO for the serial receiver. A pop and a push in the same cycle while
// full both take effect, so the caller never loses a byte in that case.
module rx_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic                  do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = count[DEPTH_LOG2];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Memory-mapped 8N1 serial receiver: synchronises rxd, deframes bytes into a
// small FIFO and exposes data/status registers on the shared operand bus.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0000_0020,
  parameter int          BAUD_DIV   = 434,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        rw,
  input  logic [31:0] addr,
  inout  logic [31:0] data,
  input  logic        rxd
);

  localparam int          TW   = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] HALF = TW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(BAUD_DIV - 1);

  logic [1:0]          sync_q;
  logic                rxs;
  logic [2:0]          state;
  logic [TW-1:0]       timer;
  logic [2:0]          idx;
  logic [7:0]          shreg;
  logic                overrun, frame_err;
  logic                push, pop, ferr_set, ovr_set;
  logic                hit_data, hit_stat, drive;
  logic                clr_ovr, clr_ferr;
  logic [7:0]          dout;
  logic                full, empty;
  logic [DEPTH_LOG2:0] count;
  logic [31:0]         rd_data;

  // Flops come out of reset at 1 so an idle line is not mistaken for a start bit.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rxd};

  assign rxs = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      timer <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (!rxs) begin
            state <= S_START;
            timer <= HALF;
          end
        S_START:
          if (timer != '0) timer <= timer - TW'(1);
          else if (rxs)    state <= S_IDLE;
          else begin
            state <= S_DATA;
            idx   <= '0;
            timer <= FULL;
          end
        S_DATA:
          if (timer != '0) timer <= timer - TW'(1);
          else begin
            shreg[idx] <= rxs;
            timer      <= FULL;
            if (idx == 3'd7) state <= S_STOP;
            else             idx   <= idx + 3'd1;
          end
        S_STOP:
          if (timer != '0) timer <= timer - TW'(1);
          else             state <= rxs ? S_IDLE : S_BREAK;
        S_BREAK:
          if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign push     = (state == S_STOP) && (timer == '0) && rxs;
  assign ferr_set = (state == S_STOP) && (timer == '0) && !rxs;

  assign hit_data = enable && (addr == BASE + SERIAL_RX_DATA);
  assign hit_stat = enable && (addr == BASE + SERIAL_RX_STAT);
  assign drive    = !rw && (hit_data || hit_stat);
  assign pop      = hit_data && !rw && !empty;
  assign ovr_set  = push && full && !pop;
  assign clr_ovr  = hit_stat && rw && data[ST_OVERRUN];
  assign clr_ferr = hit_stat && rw && data[ST_FRAME_ERR];

  rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (shreg),
    .dout    (dout),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // A flag-setting event beats a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set)       overrun <= 1'b1;
      else if (clr_ovr)  overrun <= 1'b0;
      if (ferr_set)      frame_err <= 1'b1;
      else if (clr_ferr) frame_err <= 1'b0;
    end
  end

  always_comb begin
    rd_data = rx_status(4'(count), overrun, frame_err, !empty);
    if (hit_data) rd_data = empty ? SERIAL_RX_EOF : {24'h0, dout};
  end

  assign data = drive ? rd_data : 'z;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: bus reads queue their expected value, and a
// negedge monitor pops and compares while the read is on the bus.
module tb_serial_rx;

  localparam int          BD   = 8;
  localparam logic [31:0] BASE = 32'h20;

  logic        clk = 1'b0;
  logic        reset_n, enable, rw, rxd;
  logic [31:0] addr;
  wire  [31:0] data;
  logic [31:0] bus_out;
  logic        bus_oe, sample;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  assign data = bus_oe ? bus_out : 'z;

  always #5 clk = ~clk;

  serial_rx #(.BASE(BASE), .BAUD_DIV(BD), .DEPTH_LOG2(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .rw      (rw),
    .addr    (addr),
    .data    (data),
    .rxd     (rxd)
  );

  always @(negedge clk) begin
    if (sample) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: got %h with no expected value queued", data);
      end else begin
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL %s: got %h want %h", t, data, e);
        end
      end
    end
  end

  // hold=1: bench pulls the bus to 0 so any stray DUT drive becomes visible.
  task automatic bus_chk(input logic [31:0] a, input logic en, input logic rwv,
                         input logic hold, input logic [31:0] exp, input string tag);
    @(posedge clk);
    #1;
    addr = a; enable = en; rw = rwv; bus_oe = hold; bus_out = '0;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    sample = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0; rw = 1'b0; bus_oe = 1'b0; sample = 1'b0; addr = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus_chk(a, 1'b1, 1'b0, 1'b0, exp, tag);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    @(posedge clk);
    #1;
    addr = a; enable = 1'b1; rw = 1'b1; bus_oe = 1'b1; bus_out = v;
    @(posedge clk);
    #1;
    enable = 1'b0; rw = 1'b0; bus_oe = 1'b0; addr = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low_bits);
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (BD) @(posedge clk);
    end
    if (stop_low_bits > 0) begin
      #1 rxd = 1'b0;
      repeat (BD * stop_low_bits) @(posedge clk);
    end
    #1 rxd = 1'b1;
    repeat (BD) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rxd = 1'b1; reset_n = 1'b0; enable = 1'b0; rw = 1'b0; addr = '0;
    bus_oe = 1'b0; bus_out = '0; sample = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    rd(32'h21, 32'h0, "rst_stat");
    rd(32'h20, 32'hFFFF_FFFF, "rst_eof");

    // single byte
    send_byte(8'h41, 0);
    repeat (4) @(posedge clk);
    rd(32'h21, 32'h11, "b41_stat");
    rd(32'h20, 32'h41, "b41_data");
    rd(32'h20, 32'hFFFF_FFFF, "b41_eof");

    // short glitch must not start a frame
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (20) @(posedge clk);
    rd(32'h21, 32'h0, "glitch_stat");

    // stop bit held low: one frame error, nothing pushed
    send_byte(8'h55, 20);
    repeat (10) @(posedge clk);
    rd(32'h21, 32'h02, "ferr_stat");
    rd(32'h20, 32'hFFFF_FFFF, "ferr_eof");
    wr(32'h21, 32'h2);
    rd(32'h21, 32'h0, "ferr_clr");

    // overrun
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 0);
    repeat (4) @(posedge clk);
    rd(32'h21, 32'h45, "ovr_stat");
    for (int b = 1; b <= 4; b++) rd(32'h20, 32'(b), "ovr_data");
    rd(32'h20, 32'hFFFF_FFFF, "ovr_eof");
    rd(32'h21, 32'h04, "ovr_sticky");
    wr(32'h21, 32'h4);
    rd(32'h21, 32'h0, "ovr_clr");

    // pop on the exact push edge while full
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    rd(32'h21, 32'h41, "full_stat");
    fork
      send_byte(8'h99, 0);
      begin
        repeat (78) @(posedge clk);
        rd(32'h20, 32'h11, "popush_head");
      end
    join
    repeat (4) @(posedge clk);
    rd(32'h21, 32'h41, "popush_stat");
    rd(32'h20, 32'h22, "popush_d1");
    rd(32'h20, 32'h33, "popush_d2");
    rd(32'h20, 32'h44, "popush_d3");
    rd(32'h20, 32'h99, "popush_d4");
    rd(32'h21, 32'h0, "popush_empty");

    // reset during data bits of 0xA5, released while line is high
    fork
      send_byte(8'hA5, 0);
      begin
        repeat (35) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (32) @(posedge clk);
        #1 reset_n = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    rd(32'h21, 32'h0, "rstmid_stat");
    rd(32'h20, 32'hFFFF_FFFF, "rstmid_eof");

    send_byte(8'h3C, 0);
    repeat (4) @(posedge clk);
    rd(32'h21, 32'h11, "b3c_stat");
    bus_chk(32'h20, 1'b0, 1'b0, 1'b1, 32'h0, "hiz_enable_off");
    bus_chk(32'h22, 1'b1, 1'b0, 1'b1, 32'h0, "hiz_addr_22");
    bus_chk(32'h1F, 1'b1, 1'b0, 1'b1, 32'h0, "hiz_addr_1f");
    bus_chk(32'h20, 1'b1, 1'b1, 1'b1, 32'h0, "hiz_rw_base");
    bus_chk(32'h21, 1'b1, 1'b1, 1'b1, 32'h0, "hiz_rw_stat");
    rd(32'h20, 32'h3C, "b3c_data");
    rd(32'h21, 32'h0, "b3c_empty");

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d unchecked reads want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
